// File: rtl/mac_rr_scheduler_pkg.sv
// Shared types for the MAC round-robin scheduler.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package mac_rr_scheduler_pkg;

    // Operand and accumulator widths are fixed by the shared MAC instance.
    localparam int DW = 4;
    localparam int AW = 8;

    typedef logic signed [DW-1:0] opnd_t;
    typedef logic signed [AW-1:0] acc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Perceptron output: sign test of the wrapped accumulator.
    function automatic logic is_nonneg(input acc_t v);
        return !v[AW-1];
    endfunction

endpackage

// File: rtl/mac_rr_scheduler_if.sv
// Bundle between requesters, the scheduler and the shared MAC.
// Latency: n/a (wires only).
// Backpressure: requests are levels held until the matching done; MAC busy stalls issue.
//  slave  : scheduler side (takes requests + MAC status, drives grant/result + MAC controls)
//  master : requester / MAC side
interface mac_rr_scheduler_if #(
    parameter int NREQ   = 2,
    parameter int NTERMS = 2
);
    import mac_rr_scheduler_pkg::*;

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // requester side
    logic [NREQ-1:0]           req;
    logic [NREQ*NTERMS*DW-1:0] req_x;
    logic [NREQ*NTERMS*DW-1:0] req_w;
    logic [NREQ*AW-1:0]        req_bias;
    logic [NREQ-1:0]           grant;
    logic                      done;
    logic [AW-1:0]             result;
    logic                      y;
    logic [IDW-1:0]            result_id;

    // MAC side
    logic                      mac_start;
    logic [DW-1:0]             mac_a;
    logic [DW-1:0]             mac_b;
    logic [AW-1:0]             mac_acc_init;
    logic                      mac_busy;
    logic [AW-1:0]             mac_acc_out;

    modport slave (
        input  req, req_x, req_w, req_bias, mac_busy, mac_acc_out,
        output grant, done, result, y, result_id,
               mac_start, mac_a, mac_b, mac_acc_init
    );

    modport master (
        output req, req_x, req_w, req_bias, mac_busy, mac_acc_out,
        input  grant, done, result, y, result_id,
               mac_start, mac_a, mac_b, mac_acc_init
    );

endinterface

// File: rtl/mac_rr_scheduler_rr_arbiter.sv
// Round-robin pick: first requesting index at or after the pointer, wrapping at NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
//  req     : request vector
//  ptr     : highest-priority index this round
//  gnt_oh  : one-hot winner, gnt_idx its index, gnt_vld any request present
module mac_rr_scheduler_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_vld
);

    int cand;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        // Walk the ring starting at ptr; the first hit wins.
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!gnt_vld && req[cand]) begin
                gnt_vld      = 1'b1;
                gnt_idx      = IDW'(cand);
                gnt_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_rr_scheduler.sv
// Shares one sequential MAC between NREQ perceptron requesters (bias + NTERMS products each).
// Latency: done is high in the (2*NTERMS+2)-th cycle counting the first grant cycle; 2*NTERMS+3 per op back-to-back.
// Backpressure: waits on mac_busy between passes; ena low freezes everything and gates mac_start.
//  clk, rst_n, ena : clock, async active-low reset, global enable
//  bus (slave)     : requests/operands in, grant/done/result/y/result_id out, MAC drive out, MAC status in
module mac_rr_scheduler
    import mac_rr_scheduler_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int NTERMS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    mac_rr_scheduler_if.slave bus
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW  = $clog2(NTERMS + 1);
    localparam logic [TW-1:0]  TERM_LAST = TW'(NTERMS);
    localparam logic [IDW-1:0] OWNER_MAX = IDW'(NREQ - 1);

    state_t          state_q,  state_d;
    logic [NREQ-1:0] grant_q,  grant_d;
    logic [IDW-1:0]  owner_q,  owner_d;
    logic [IDW-1:0]  ptr_q,    ptr_d;
    logic [TW-1:0]   term_q,   term_d;
    acc_t            result_q, result_d;
    logic            y_q,      y_d;
    logic [IDW-1:0]  rid_q,    rid_d;
    logic            done_q,   done_d;

    logic [NREQ-1:0] arb_oh;
    logic [IDW-1:0]  arb_idx;
    logic            arb_vld;

    logic            mac_ready;
    logic            more_terms;
    opnd_t           x_sel, w_sel;
    acc_t            bias_sel;
    logic            mac_start_c;
    opnd_t           mac_a_c, mac_b_c;
    acc_t            mac_init_c;

    mac_rr_scheduler_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // A previous pass has completed and its sum is on mac_acc_out.
    assign mac_ready  = (state_q == ST_WAIT) && !bus.mac_busy;
    assign more_terms = (term_q != TERM_LAST);

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            term_q   <= '0;
            result_q <= '0;
            y_q      <= 1'b0;
            rid_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            term_q   <= term_d;
            result_q <= result_d;
            y_q      <= y_d;
            rid_q    <= rid_d;
            done_q   <= done_d;
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        term_d   = term_q;
        result_d = result_q;
        y_d      = y_q;
        rid_d    = rid_q;
        done_d   = done_q;
        if (ena) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant_d = arb_oh;
                        owner_d = arb_idx;
                        term_d  = '0;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    term_d  = TW'(1);
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (!bus.mac_busy) begin
                        if (more_terms) begin
                            term_d = term_q + TW'(1);
                        end else begin
                            result_d = bus.mac_acc_out;
                            y_d      = is_nonneg(bus.mac_acc_out);
                            rid_d    = owner_q;
                            done_d   = 1'b1;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Owner drops to lowest priority so a waiting peer goes next.
                    grant_d = '0;
                    ptr_d   = (owner_q == OWNER_MAX) ? '0 : owner_q + IDW'(1);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin : out_comb
        x_sel    = '0;
        w_sel    = '0;
        bias_sel = '0;
        // term_q is 0 in ISSUE, so the same mux serves the first and later passes.
        for (int r = 0; r < NREQ; r++) begin
            if (owner_q == IDW'(r)) begin
                bias_sel = bus.req_bias[r*AW +: AW];
                for (int k = 0; k < NTERMS; k++) begin
                    if (term_q == TW'(k)) begin
                        x_sel = bus.req_x[(r*NTERMS+k)*DW +: DW];
                        w_sel = bus.req_w[(r*NTERMS+k)*DW +: DW];
                    end
                end
            end
        end

        mac_start_c = ena && ((state_q == ST_ISSUE) || (mac_ready && more_terms));
        mac_a_c     = '0;
        mac_b_c     = '0;
        mac_init_c  = '0;
        if (mac_start_c) begin
            mac_a_c    = x_sel;
            mac_b_c    = w_sel;
            // Bias seeds the chain; later passes accumulate onto the MAC's own output.
            mac_init_c = (state_q == ST_ISSUE) ? bias_sel : acc_t'(bus.mac_acc_out);
        end
    end

    assign bus.grant        = grant_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.y            = y_q;
    assign bus.result_id    = rid_q;
    assign bus.mac_start    = mac_start_c;
    assign bus.mac_a        = mac_a_c;
    assign bus.mac_b        = mac_b_c;
    assign bus.mac_acc_init = mac_init_c;

endmodule
